// File: rtl/instruction_fetch_unit.sv
// Instruction fetch front-end: PC, valid/ready fetch channel, prefetch queue, redirect flush.
// Optional macro FETCH_PERF_COUNTERS_EN adds stall-cycle and flush counters.
module instruction_fetch_unit #(
  parameter int                       ADDRESS_WIDTH = 32,
  parameter int                       QUEUE_DEPTH   = 4,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_VECTOR  = '0
) (
  input  logic                     clock,
  input  logic                     reset,
  output logic                     imem_request_valid,
  input  logic                     imem_request_ready,
  output logic [ADDRESS_WIDTH-1:0] imem_address,
  input  logic                     imem_response_valid,
  input  logic [31:0]              imem_response_data,
  output logic                     instruction_valid,
  input  logic                     instruction_ready,
  output logic [31:0]              instruction,
  output logic [ADDRESS_WIDTH-1:0] instruction_pc,
  output logic [ADDRESS_WIDTH-1:0] pc_plus_8,
  input  logic                     pc_source,
  input  logic [ADDRESS_WIDTH-1:0] branch_target
`ifdef FETCH_PERF_COUNTERS_EN
  ,
  output logic [31:0]              perf_stall_cycles,
  output logic [15:0]              perf_flushes
`endif
);

  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ADDRESS_WIDTH-1:0] ALIGN_MASK = ~ADDRESS_WIDTH'(3);

  typedef enum logic [1:0] {BOOT, FETCH, FLUSH} state_t;

  state_t                   state;
  logic [ADDRESS_WIDTH-1:0] fetch_pc;
  logic [ADDRESS_WIDTH-1:0] resp_pc;
  logic [PTR_W-1:0]         head;
  logic [PTR_W-1:0]         tail;
  logic [CNT_W-1:0]         occupancy;
  logic [CNT_W-1:0]         outstanding;
  logic [CNT_W-1:0]         drop_count;

  logic [31:0]              q_data [QUEUE_DEPTH];
  logic [ADDRESS_WIDTH-1:0] q_pc   [QUEUE_DEPTH];

  logic [CNT_W:0]           in_use;
  logic [CNT_W-1:0]         out_next;
  logic [ADDRESS_WIDTH-1:0] target_aligned;
  logic                     redirect;
  logic                     req_fire;
  logic                     pop;
  logic                     drop;
  logic                     push;

  always_comb begin
    in_use             = {1'b0, occupancy} + {1'b0, outstanding};
    redirect           = pc_source && (state != BOOT);
    imem_request_valid = (state == FETCH) && !pc_source &&
                         (in_use < (CNT_W+1)'(QUEUE_DEPTH));
    imem_address       = fetch_pc;
    req_fire           = imem_request_valid && imem_request_ready;
    instruction_valid  = (occupancy != '0);
    pop                = instruction_valid && instruction_ready;
    drop               = imem_response_valid && (drop_count != '0);
    // A response arriving with a redirect is stale by definition.
    push               = imem_response_valid && (drop_count == '0) && !redirect;
    out_next           = outstanding + CNT_W'(req_fire) - CNT_W'(imem_response_valid);
    target_aligned     = branch_target & ALIGN_MASK;
  end

  // Head is gated so an empty queue presents zeros rather than stale storage.
  always_comb begin
    instruction    = instruction_valid ? q_data[head] : '0;
    instruction_pc = instruction_valid ? q_pc[head] : '0;
    pc_plus_8      = instruction_pc + ADDRESS_WIDTH'(8);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= BOOT;
      fetch_pc    <= RESET_VECTOR & ALIGN_MASK;
      resp_pc     <= RESET_VECTOR & ALIGN_MASK;
      head        <= '0;
      tail        <= '0;
      occupancy   <= '0;
      outstanding <= '0;
      drop_count  <= '0;
    end else begin
      outstanding <= out_next;
      if (redirect) begin
        fetch_pc   <= target_aligned;
        resp_pc    <= target_aligned;
        head       <= '0;
        tail       <= '0;
        occupancy  <= '0;
        drop_count <= out_next;
        state      <= (out_next != '0) ? FLUSH : FETCH;
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + ADDRESS_WIDTH'(4);
        if (push) begin
          tail    <= tail + PTR_W'(1);
          resp_pc <= resp_pc + ADDRESS_WIDTH'(4);
        end
        if (pop) head <= head + PTR_W'(1);
        occupancy <= occupancy + CNT_W'(push) - CNT_W'(pop);
        if (drop) drop_count <= drop_count - CNT_W'(1);
        case (state)
          BOOT:    state <= FETCH;
          FLUSH:   if ((drop_count == '0) || ((drop_count == CNT_W'(1)) && drop)) state <= FETCH;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      q_data[tail] <= imem_response_data;
      q_pc[tail]   <= resp_pc;
    end
  end

`ifdef FETCH_PERF_COUNTERS_EN
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (&v) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      perf_stall_cycles <= '0;
      perf_flushes      <= '0;
    end else begin
      if ((state != BOOT) && !instruction_valid) perf_stall_cycles <= sat_inc32(perf_stall_cycles);
      if (redirect) perf_flushes <= sat_inc16(perf_flushes);
    end
  end
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: fixed-latency memory model, vector table, corner sequences.
module tb_instruction_fetch_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        imem_request_valid;
  logic        imem_request_ready;
  logic [31:0] imem_address;
  logic        imem_response_valid;
  logic [31:0] imem_response_data;
  logic        instruction_valid;
  logic        instruction_ready;
  logic [31:0] instruction;
  logic [31:0] instruction_pc;
  logic [31:0] pc_plus_8;
  logic        pc_source;
  logic [31:0] branch_target;
`ifdef FETCH_PERF_COUNTERS_EN
  logic [31:0] perf_stall_cycles;
  logic [15:0] perf_flushes;
`endif

  instruction_fetch_unit dut (
    .clock               (clock),
    .reset               (reset),
    .imem_request_valid  (imem_request_valid),
    .imem_request_ready  (imem_request_ready),
    .imem_address        (imem_address),
    .imem_response_valid (imem_response_valid),
    .imem_response_data  (imem_response_data),
    .instruction_valid   (instruction_valid),
    .instruction_ready   (instruction_ready),
    .instruction         (instruction),
    .instruction_pc      (instruction_pc),
    .pc_plus_8           (pc_plus_8),
    .pc_source           (pc_source),
    .branch_target       (branch_target)
`ifdef FETCH_PERF_COUNTERS_EN
    ,
    .perf_stall_cycles   (perf_stall_cycles),
    .perf_flushes        (perf_flushes)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  typedef struct {
    bit          rst;
    bit          irdy;
    bit          rv;
    logic [31:0] addr;
    bit          iv;
    logic [31:0] pc;
  } vec_t;

  pend_t pend[$];
  vec_t  tbl[19];
  int    cyc;
  int    lat;
  int    total = 0;
  int    bad   = 0;

  function automatic logic [31:0] memword(input logic [31:0] a);
    return a ^ 32'hE3A0_5000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic do_reset(input int l);
    reset               = 1'b0;
    imem_request_ready  = 1'b1;
    imem_response_valid = 1'b0;
    imem_response_data  = '0;
    instruction_ready   = 1'b0;
    pc_source           = 1'b0;
    branch_target       = '0;
    pend.delete();
    @(negedge clock);
    @(negedge clock);
    chk("rst_req_valid", {31'd0, imem_request_valid}, 32'd0);
    chk("rst_instr_valid", {31'd0, instruction_valid}, 32'd0);
    chk("rst_instr", instruction, 32'd0);
    chk("rst_pc", instruction_pc, 32'd0);
    chk("rst_pc8", pc_plus_8, 32'd8);
`ifdef FETCH_PERF_COUNTERS_EN
    chk("rst_perf_stall", perf_stall_cycles, 32'd0);
    chk("rst_perf_flush", {16'd0, perf_flushes}, 32'd0);
`endif
    reset = 1'b1;
    cyc   = 0;
    lat   = l;
  endtask

  task automatic drive(input bit irdy, input bit psrc, input logic [31:0] tgt);
    instruction_ready = irdy;
    pc_source         = psrc;
    branch_target     = tgt;
    #1;
  endtask

  // Captures this cycle's handshake, then presents any due response for the next cycle.
  task automatic tick();
    if (imem_request_valid && imem_request_ready) pend.push_back('{imem_address, cyc + lat});
    @(posedge clock);
    cyc++;
    @(negedge clock);
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      imem_response_valid = 1'b1;
      imem_response_data  = memword(pend[0].addr);
      void'(pend.pop_front());
    end else begin
      imem_response_valid = 1'b0;
      imem_response_data  = '0;
    end
  endtask

  task automatic chk_head(input string name, input logic [31:0] pc);
    chk({name, "_iv"}, {31'd0, instruction_valid}, 32'd1);
    chk({name, "_pc"}, instruction_pc, pc);
    chk({name, "_pc8"}, pc_plus_8, pc + 32'd8);
    chk({name, "_word"}, instruction, memword(pc));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          found;
    logic [31:0] fpc;

    // Streaming, decode always ready
    tbl[0]  = '{1, 1, 0, 32'h0,  0, 32'h0};
    tbl[1]  = '{0, 1, 1, 32'h0,  0, 32'h0};
    tbl[2]  = '{0, 1, 1, 32'h4,  0, 32'h0};
    tbl[3]  = '{0, 1, 1, 32'h8,  1, 32'h0};
    tbl[4]  = '{0, 1, 1, 32'hC,  1, 32'h4};
    tbl[5]  = '{0, 1, 1, 32'h10, 1, 32'h8};
    tbl[6]  = '{0, 1, 1, 32'h14, 1, 32'hC};
    tbl[7]  = '{0, 1, 1, 32'h18, 1, 32'h10};
    // Decode stalled: queue fills, one pop frees one request
    tbl[8]  = '{1, 0, 0, 32'h0,  0, 32'h0};
    tbl[9]  = '{0, 0, 1, 32'h0,  0, 32'h0};
    tbl[10] = '{0, 0, 1, 32'h4,  0, 32'h0};
    tbl[11] = '{0, 0, 1, 32'h8,  1, 32'h0};
    tbl[12] = '{0, 0, 1, 32'hC,  1, 32'h0};
    tbl[13] = '{0, 0, 0, 32'h0,  1, 32'h0};
    tbl[14] = '{0, 0, 0, 32'h0,  1, 32'h0};
    tbl[15] = '{0, 1, 0, 32'h0,  1, 32'h0};
    tbl[16] = '{0, 0, 1, 32'h10, 1, 32'h4};
    tbl[17] = '{0, 0, 0, 32'h0,  1, 32'h4};
    tbl[18] = '{0, 0, 0, 32'h0,  1, 32'h4};

    cyc = 0;
    lat = 1;
    for (int i = 0; i < 19; i++) begin
      if (tbl[i].rst) do_reset(1);
      drive(tbl[i].irdy, 1'b0, 32'h0);
      chk($sformatf("vec%0d_rv", i), {31'd0, imem_request_valid}, {31'd0, tbl[i].rv});
      if (tbl[i].rv) chk($sformatf("vec%0d_addr", i), imem_address, tbl[i].addr);
      chk($sformatf("vec%0d_iv", i), {31'd0, instruction_valid}, {31'd0, tbl[i].iv});
      if (tbl[i].iv) chk_head($sformatf("vec%0d", i), tbl[i].pc);
      tick();
    end

    // Redirect with two stale fetches in flight (latency 3)
    do_reset(3);
    drive(1, 0, 0); tick();
    drive(1, 0, 0); chk("lat3_addr0", imem_address, 32'h0); tick();
    drive(1, 0, 0); chk("lat3_addr4", imem_address, 32'h4); tick();
    drive(1, 1, 32'h103);
    chk("redir_rv_forced", {31'd0, imem_request_valid}, 32'd0);
    tick();
    drive(1, 0, 0);
    chk("flush1_rv", {31'd0, imem_request_valid}, 32'd0);
    chk("flush1_iv", {31'd0, instruction_valid}, 32'd0);
    tick();
    drive(1, 0, 0);
    chk("flush2_rv", {31'd0, imem_request_valid}, 32'd0);
    chk("flush2_iv", {31'd0, instruction_valid}, 32'd0);
    tick();
    drive(1, 0, 0);
    chk("post_flush_rv", {31'd0, imem_request_valid}, 32'd1);
    chk("post_flush_addr", imem_address, 32'h100);
    tick();
    found = 1'b0;
    fpc   = '0;
    for (int k = 0; k < 8 && !found; k++) begin
      drive(1, 0, 0);
      if (instruction_valid) begin
        found = 1'b1;
        fpc   = instruction_pc;
        chk("redir_first_word", instruction, memword(32'h100));
      end else begin
        tick();
      end
    end
    chk("redir_first_found", {31'd0, found}, 32'd1);
    chk("redir_first_pc", fpc, 32'h100);

    // Redirect coinciding with a pop, three entries queued
    do_reset(1);
    for (int k = 0; k < 5; k++) begin
      drive(0, 0, 0); tick();
    end
    drive(1, 1, 32'h200);
    chk_head("pop_redir_head", 32'h0);
    tick();
    drive(1, 0, 0);
    chk("pop_redir_empty", {31'd0, instruction_valid}, 32'd0);
    chk("pop_redir_rv", {31'd0, imem_request_valid}, 32'd1);
    chk("pop_redir_addr", imem_address, 32'h200);
    tick();
    drive(1, 0, 0);
    chk("pop_redir_empty2", {31'd0, instruction_valid}, 32'd0);
    tick();
    drive(1, 0, 0);
    chk_head("pop_redir_new", 32'h200);
    tick();

    // Address wrap at top of memory
    do_reset(1);
    drive(1, 0, 0); tick();
    drive(1, 1, 32'hFFFF_FFFF);
    chk("wrap_redir_rv", {31'd0, imem_request_valid}, 32'd0);
    tick();
    drive(1, 0, 0); chk("wrap_addr_top", imem_address, 32'hFFFF_FFFC); tick();
    drive(1, 0, 0);
    chk("wrap_rv", {31'd0, imem_request_valid}, 32'd1);
    chk("wrap_addr_zero", imem_address, 32'h0);
    tick();
    drive(1, 0, 0);
    chk_head("wrap_head_top", 32'hFFFF_FFFC);
    chk("wrap_pc8_value", pc_plus_8, 32'h4);
    tick();
    drive(1, 0, 0);
    chk_head("wrap_head_zero", 32'h0);
    tick();

`ifdef FETCH_PERF_COUNTERS_EN
    // Empty cycles after boot: 1,2,5,6,8; redirects at 4 and 7
    do_reset(1);
    for (int k = 0; k < 9; k++) begin
      drive(1, (k == 4) || (k == 7), (k == 4) ? 32'h40 : 32'h80);
      tick();
    end
    drive(1, 0, 0);
    chk("perf_flushes", {16'd0, perf_flushes}, 32'd2);
    chk("perf_stall_cycles", perf_stall_cycles, 32'd5);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
